// File: rtl/matrix_vector_loader.sv
// matrix_vector_loader: double-buffered serial-to-parallel operand loader for a 4x4 matrix-vector engine
module matrix_vector_loader #(
  parameter int W     = 64,
  parameter int FRAME = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  output logic [W-1:0] mat_0_0,
  output logic [W-1:0] mat_0_1,
  output logic [W-1:0] mat_0_2,
  output logic [W-1:0] mat_0_3,
  output logic [W-1:0] mat_1_0,
  output logic [W-1:0] mat_1_1,
  output logic [W-1:0] mat_1_2,
  output logic [W-1:0] mat_1_3,
  output logic [W-1:0] mat_2_0,
  output logic [W-1:0] mat_2_1,
  output logic [W-1:0] mat_2_2,
  output logic [W-1:0] mat_2_3,
  output logic [W-1:0] mat_3_0,
  output logic [W-1:0] mat_3_1,
  output logic [W-1:0] mat_3_2,
  output logic [W-1:0] mat_3_3,
  output logic [W-1:0] vector_0,
  output logic [W-1:0] vector_1,
  output logic [W-1:0] vector_2,
  output logic [W-1:0] vector_3,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [7:0]   err_count
);
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;
  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         fill_full_q, fill_full_d;
  logic         o_valid_q, o_valid_d;
  logic [7:0]   err_q, err_d;
  logic [W-1:0] fill_q [FRAME];
  logic [W-1:0] fill_d [FRAME];
  logic [W-1:0] out_q  [FRAME];
  logic [W-1:0] out_d  [FRAME];
  logic         in_xfer, err_inc;
  // i_ready is a pure state decode so it never depends on o_ready
  assign i_ready = (state_q == S_FILL) || (state_q == S_FLUSH);
  assign in_xfer = i_valid && i_ready;
  // fill-side FSM, bank copy and output-valid bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_full_d = fill_full_q;
    o_valid_d   = o_valid_q;
    fill_d      = fill_q;
    out_d       = out_q;
    err_inc     = 1'b0;
    if (o_valid_q && o_ready) o_valid_d = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_xfer) begin
          fill_d[cnt_q] = i_data;
          if (cnt_q == 5'(FRAME - 1)) begin
            cnt_d = '0;
            if (i_last) begin
              fill_full_d = 1'b1;
              state_d     = S_FULL;
            end else begin
              err_inc = 1'b1;
              fill_d  = '{default: '0};
              state_d = S_FLUSH;
            end
          end else if (i_last) begin
            err_inc = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_FULL: begin
        if (fill_full_q && (!o_valid_q || o_ready)) begin
          out_d       = fill_q;
          o_valid_d   = 1'b1;
          fill_full_d = 1'b0;
          state_d     = S_FILL;
        end
      end
      S_FLUSH: begin
        if (in_xfer && i_last) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
      end
    endcase
    err_d = err_q + 8'(err_inc && (err_q != 8'hff));
  end
  // state and bank registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      fill_full_q <= 1'b0;
      o_valid_q   <= 1'b0;
      err_q       <= '0;
      fill_q      <= '{default: '0};
      out_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_full_q <= fill_full_d;
      o_valid_q   <= o_valid_d;
      err_q       <= err_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
    end
  end
  assign mat_0_0   = out_q[0];
  assign mat_0_1   = out_q[1];
  assign mat_0_2   = out_q[2];
  assign mat_0_3   = out_q[3];
  assign mat_1_0   = out_q[4];
  assign mat_1_1   = out_q[5];
  assign mat_1_2   = out_q[6];
  assign mat_1_3   = out_q[7];
  assign mat_2_0   = out_q[8];
  assign mat_2_1   = out_q[9];
  assign mat_2_2   = out_q[10];
  assign mat_2_3   = out_q[11];
  assign mat_3_0   = out_q[12];
  assign mat_3_1   = out_q[13];
  assign mat_3_2   = out_q[14];
  assign mat_3_3   = out_q[15];
  assign vector_0  = out_q[16];
  assign vector_1  = out_q[17];
  assign vector_2  = out_q[18];
  assign vector_3  = out_q[19];
  assign o_valid   = o_valid_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_matrix_vector_loader.sv
// tb_matrix_vector_loader: directed self-checking bench for matrix_vector_loader
module tb_matrix_vector_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b1;
  logic        o_ready = 1'b0;
  logic [63:0] i_data = 64'hdead_beef_0bad_f00d;
  logic        i_ready, o_valid;
  logic [7:0]  err_count;
  logic [63:0] m00, m01, m02, m03, m10, m11, m12, m13;
  logic [63:0] m20, m21, m22, m23, m30, m31, m32, m33;
  logic [63:0] v0, v1, v2, v3;
  logic [63:0] o_vec [20];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    int          idx;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [6];

  matrix_vector_loader #(.W(64), .FRAME(20)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
    .mat_0_0(m00), .mat_0_1(m01), .mat_0_2(m02), .mat_0_3(m03),
    .mat_1_0(m10), .mat_1_1(m11), .mat_1_2(m12), .mat_1_3(m13),
    .mat_2_0(m20), .mat_2_1(m21), .mat_2_2(m22), .mat_2_3(m23),
    .mat_3_0(m30), .mat_3_1(m31), .mat_3_2(m32), .mat_3_3(m33),
    .vector_0(v0), .vector_1(v1), .vector_2(v2), .vector_3(v3),
    .o_valid(o_valid), .o_ready(o_ready), .err_count(err_count)
  );

  assign o_vec[0]  = m00;
  assign o_vec[1]  = m01;
  assign o_vec[2]  = m02;
  assign o_vec[3]  = m03;
  assign o_vec[4]  = m10;
  assign o_vec[5]  = m11;
  assign o_vec[6]  = m12;
  assign o_vec[7]  = m13;
  assign o_vec[8]  = m20;
  assign o_vec[9]  = m21;
  assign o_vec[10] = m22;
  assign o_vec[11] = m23;
  assign o_vec[12] = m30;
  assign o_vec[13] = m31;
  assign o_vec[14] = m32;
  assign o_vec[15] = m33;
  assign o_vec[16] = v0;
  assign o_vec[17] = v1;
  assign o_vec[18] = v2;
  assign o_vec[19] = v3;

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wd(input int x);
    return $realtobits(real'(x));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    int t = 0;
    while (!i_ready && t < 200) begin
      tick();
      t++;
    end
    if (!i_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: i_ready got 0 expected 1");
    end
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b1;
    i_data  = 64'hdead_beef_0bad_f00d;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < 20; k++) send(wd(base + k), k == 19);
  endtask

  initial begin
    tbl[0] = '{"mat_0_0", 0, 64'h3FF0000000000000};
    tbl[1] = '{"mat_0_1", 1, 64'h4000000000000000};
    tbl[2] = '{"mat_1_1", 5, 64'h4018000000000000};
    tbl[3] = '{"mat_3_3", 15, 64'h4030000000000000};
    tbl[4] = '{"vector_0", 16, 64'h4031000000000000};
    tbl[5] = '{"vector_3", 19, 64'h4034000000000000};

    #1 rst = 1'b0;
    #2;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_mat_0_0", m00, 64'd0);
    #18 rst = 1'b1;
    tick();
    chk("rst_i_ready", 64'(i_ready), 64'd1);

    // basic frame 1.0 .. 20.0
    o_ready = 1'b1;
    send_frame(1);
    chk("basic_o_valid_lat1", 64'(o_valid), 64'd0);
    chk("basic_i_ready_full", 64'(i_ready), 64'd0);
    tick();
    chk("basic_o_valid_lat2", 64'(o_valid), 64'd1);
    for (int i = 0; i < 6; i++) chk(tbl[i].name, o_vec[tbl[i].idx], tbl[i].exp);
    chk("basic_err", 64'(err_count), 64'd0);
    tick();
    chk("basic_consumed", 64'(o_valid), 64'd0);

    // back-pressure / double buffer
    o_ready = 1'b0;
    send_frame(1000);
    tick();
    chk("bp_a_valid", 64'(o_valid), 64'd1);
    send_frame(1100);
    chk("bp_b_i_ready", 64'(i_ready), 64'd0);
    repeat (5) tick();
    chk("bp_stall_i_ready", 64'(i_ready), 64'd0);
    chk("bp_stall_o_valid", 64'(o_valid), 64'd1);
    chk("bp_a_mat_0_0", m00, wd(1000));
    chk("bp_a_vector_3", v3, wd(1019));
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    chk("bp_b_o_valid", 64'(o_valid), 64'd1);
    chk("bp_b_mat_0_0", m00, wd(1100));
    chk("bp_b_mat_3_3", m33, wd(1115));
    chk("bp_b_vector_3", v3, wd(1119));
    chk("bp_b_i_ready", 64'(i_ready), 64'd1);

    // output hold after transfer
    o_ready = 1'b1;
    tick();
    chk("hold_o_valid_drop", 64'(o_valid), 64'd0);
    repeat (16) tick();
    chk("hold_o_valid", 64'(o_valid), 64'd0);
    chk("hold_mat_0_0", m00, wd(1100));
    chk("hold_mat_2_2", m22, wd(1110));
    chk("hold_vector_3", v3, wd(1119));

    // early i_last on word 7
    for (int k = 0; k < 7; k++) send(wd(200 + k), k == 6);
    chk("early_err", 64'(err_count), 64'd1);
    chk("early_o_valid", 64'(o_valid), 64'd0);
    send_frame(300);
    tick();
    chk("early_next_valid", 64'(o_valid), 64'd1);
    chk("early_next_mat_0_0", m00, wd(300));
    chk("early_next_vector_3", v3, wd(319));
    chk("early_next_err", 64'(err_count), 64'd1);

    // missing i_last at word 20, then flush
    for (int k = 0; k < 20; k++) send(wd(400 + k), 1'b0);
    chk("miss_err", 64'(err_count), 64'd2);
    chk("miss_flush_i_ready", 64'(i_ready), 64'd1);
    for (int k = 0; k < 5; k++) send(wd(450 + k), k == 4);
    chk("miss_flush_no_frame", 64'(o_valid), 64'd0);
    send_frame(500);
    tick();
    chk("miss_next_valid", 64'(o_valid), 64'd1);
    chk("miss_next_mat_0_0", m00, wd(500));
    chk("miss_next_vector_0", v0, wd(516));
    chk("miss_next_err", 64'(err_count), 64'd2);

    // saturation of the error counter
    for (int k = 0; k < 252; k++) send(wd(k), 1'b1);
    chk("sat_254", 64'(err_count), 64'd254);
    send(wd(7), 1'b1);
    chk("sat_255", 64'(err_count), 64'd255);
    for (int k = 0; k < 47; k++) send(wd(k), 1'b1);
    chk("sat_hold", 64'(err_count), 64'd255);

    // asynchronous reset mid-frame
    o_ready = 1'b0;
    send_frame(600);
    tick();
    chk("arst_pre_valid", 64'(o_valid), 64'd1);
    for (int k = 0; k < 10; k++) send(wd(700 + k), 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_o_valid", 64'(o_valid), 64'd0);
    chk("arst_mat_0_0", m00, 64'd0);
    chk("arst_vector_3", v3, 64'd0);
    chk("arst_err", 64'(err_count), 64'd0);
    #1 rst = 1'b1;
    tick();
    o_ready = 1'b1;
    send_frame(800);
    tick();
    chk("arst_next_valid", 64'(o_valid), 64'd1);
    chk("arst_next_mat_0_0", m00, wd(800));
    chk("arst_next_mat_2_1", m21, wd(809));
    chk("arst_next_vector_3", v3, wd(819));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
